// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between fetch and imem.
// One outstanding request; responses carry no tag.
interface fetch_stage_if #(
  parameter int XLEN = 32
) ();
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: PC, variable-latency imem fetch, one-entry stall buffer,
// flush-kill of in-flight fetches, and the IF/ID pipeline register.
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] PC_STEP   = XLEN'(4),
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCWrite,
  input  logic            IF_ID_Write,
  input  logic            IF_Flush,
  input  logic [XLEN-1:0] BranchTarget,
  fetch_stage_if.master   imem,
  output logic [XLEN-1:0] IF_ID_PC,
  output logic [31:0]     IF_ID_Instr,
  output logic            IF_ID_Valid
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } slot_t;

  logic [1:0]      state;
  logic [1:0]      state_n;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_n;
  logic [XLEN-1:0] req_pc;
  slot_t           buf_q;
  slot_t           buf_n;
  logic            buf_valid;
  logic            buf_valid_n;
  slot_t           ifid_n;
  logic            ifid_valid_n;

  logic in_idle;
  logic in_wait;
  logic in_disc;
  logic rvalid;
  logic rsp;
  logic issue;

  assign in_idle = (state == IDLE);
  assign in_wait = (state == WAIT);
  assign in_disc = (state == DISCARD);
  assign rvalid  = imem.imem_rvalid;
  assign rsp     = in_wait & rvalid;

  // A response consumed straight into IF/ID frees the single slot,
  // so the next fetch may go out in the same cycle.
  assign issue = !rst && !IF_Flush && PCWrite && !buf_valid &&
                 (in_idle || (rsp && IF_ID_Write));

  assign imem.imem_req  = issue;
  assign imem.imem_addr = pc;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    buf_n        = buf_q;
    buf_valid_n  = buf_valid;
    ifid_n       = '{pc: IF_ID_PC, instr: IF_ID_Instr};
    ifid_valid_n = IF_ID_Valid;

    if (IF_Flush) begin
      pc_n         = {BranchTarget[XLEN-1:2], 2'b00};
      ifid_n.instr = NOP_INSTR;
      ifid_valid_n = 1'b0;
      buf_valid_n  = 1'b0;
      unique case (1'b1)
        in_wait: state_n = rvalid ? IDLE : DISCARD;
        in_disc: state_n = rvalid ? IDLE : DISCARD;
        default: state_n = IDLE;
      endcase
    end else begin
      if (issue) begin
        pc_n = pc + PC_STEP;
      end

      if (rsp && !IF_ID_Write) begin
        buf_n       = '{pc: req_pc, instr: imem.imem_rdata};
        buf_valid_n = 1'b1;
      end

      if (IF_ID_Write) begin
        if (rsp) begin
          ifid_n       = '{pc: req_pc, instr: imem.imem_rdata};
          ifid_valid_n = 1'b1;
        end else if (in_idle && buf_valid) begin
          ifid_n       = buf_q;
          ifid_valid_n = 1'b1;
          buf_valid_n  = 1'b0;
        end else begin
          ifid_n.instr = NOP_INSTR;
          ifid_valid_n = 1'b0;
        end
      end

      if (issue) begin
        state_n = WAIT;
      end else if (rsp || (in_disc && rvalid)) begin
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_pc      <= RESET_PC;
      buf_q       <= '0;
      buf_valid   <= 1'b0;
      IF_ID_PC    <= '0;
      IF_ID_Instr <= NOP_INSTR;
      IF_ID_Valid <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      buf_q       <= buf_n;
      buf_valid   <= buf_valid_n;
      IF_ID_PC    <= ifid_n.pc;
      IF_ID_Instr <= ifid_n.instr;
      IF_ID_Valid <= ifid_valid_n;
      if (issue) begin
        req_pc <= pc;
      end
    end
  end

endmodule
